bg_tile_fetch_seq: RTL and testbench

Background tile fetch sequencer for the PPU. For each scanline it walks the tile columns and drives the external nametable address translator with the row/column position. For each tile it issues the four VRAM reads in order: nametable, attribute, pattern low, pattern high. Each assembled tile (pattern bytes plus 2-bit palette) is handed to the background shift-register stage over a valid/ready handshake. It sits between the scanline timing logic and the shared VRAM read port.

---
 rtl/bg_tile_fetch_seq_pkg.sv | 27 ++
 rtl/bg_tile_fetch_seq_attr_addr_gen.sv | 19 +
 rtl/bg_tile_fetch_seq.sv | 145 ++++++++++++++
 tb/tb_bg_tile_fetch_seq.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bg_tile_fetch_seq_pkg.sv
// Shared PPU background-fetch definitions: sequencer states and VRAM map constants.
package bg_tile_fetch_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_NT   = 3'd1,
        ST_AT   = 3'd2,
        ST_PLO  = 3'd3,
        ST_PHI  = 3'd4,
        ST_OUT  = 3'd5,
        ST_DONE = 3'd6
    } fetch_state_t;

    localparam logic [15:0] ATTR_BASE     = 16'h23C0;
    localparam logic [15:0] PAT_BASE_1    = 16'h1000;
    localparam logic [15:0] PAT_HI_OFFSET = 16'd8;

    // Plane-0 pattern byte address; the plane-1 byte sits PAT_HI_OFFSET above it.
    function automatic logic [15:0] pat_addr(input logic       hi_table,
                                             input logic [7:0] tile_num,
                                             input logic [2:0] fine);
        return (hi_table ? PAT_BASE_1 : 16'h0000)
             + {4'b0000, tile_num, 4'b0000}
             + {13'd0, fine};
    endfunction

endpackage

// File: rtl/bg_tile_fetch_seq_attr_addr_gen.sv
// Nametable pointer to attribute-byte address and palette bit offset within that byte.
// Purely combinational; shared with sprite-0 and debug logic.
module bg_attr_addr_gen
    import bg_tile_fetch_seq_pkg::*;
(
    input  logic [15:0] nt_ptr,
    output logic [15:0] attr_addr,
    output logic [2:0]  attr_shift
);

    assign attr_addr = ATTR_BASE
                     | (nt_ptr & 16'h0C00)
                     | ((nt_ptr >> 4) & 16'h0038)
                     | ((nt_ptr >> 2) & 16'h0007);

    // Quadrant select: coarse-Y bit 1 lives in nt_ptr[6], coarse-X bit 1 in nt_ptr[1].
    assign attr_shift = {nt_ptr[6], nt_ptr[1], 1'b0};

endmodule

// File: rtl/bg_tile_fetch_seq.sv
// Background tile fetch sequencer: per tile NT/AT/PLO/PHI reads, then a valid/ready tile hand-off.
// One cycle per access at zero wait; stalls in OUT while tile_ready is low, holding all outputs.
module bg_tile_fetch_seq
    import bg_tile_fetch_seq_pkg::*;
#(
    parameter int TILES_PER_LINE = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        line_start,
    input  logic [8:0]  line_row,
    input  logic [7:0]  ppu_ctrl1,
    output logic [8:0]  xlat_row,
    output logic [8:0]  xlat_col,
    input  logic [15:0] xlat_nt_ptr,
    input  logic [2:0]  xlat_fine_row,
    output logic        vram_req,
    output logic [15:0] vram_addr,
    input  logic        vram_ack,
    input  logic [7:0]  vram_rdata,
    output logic        tile_valid,
    input  logic        tile_ready,
    output logic [7:0]  tile_pat_lo,
    output logic [7:0]  tile_pat_hi,
    output logic [1:0]  tile_pal,
    output logic        line_done,
    output logic        busy
);

    localparam logic [5:0] LAST_TILE = 6'(TILES_PER_LINE - 1);

    fetch_state_t state;
    logic [8:0]   row_q;
    logic [5:0]   tile_idx;
    logic [15:0]  nt_ptr_q;
    logic [2:0]   fine_q;
    logic [7:0]   tile_num_q;
    logic [7:0]   lo_q;
    logic [7:0]   hi_q;
    logic [1:0]   pal_q;

    logic [15:0]  attr_addr;
    logic [2:0]   attr_shift;
    logic [15:0]  pat_lo_addr;
    logic         unused_ctrl;

    assign unused_ctrl = ^{ppu_ctrl1[7:5], ppu_ctrl1[3:0]};

    bg_attr_addr_gen u_attr_addr_gen (
        .nt_ptr     (nt_ptr_q),
        .attr_addr  (attr_addr),
        .attr_shift (attr_shift)
    );

    // Pattern table select follows ppu_ctrl1 live rather than being latched per tile.
    assign pat_lo_addr = pat_addr(ppu_ctrl1[4], tile_num_q, fine_q);

    assign xlat_row = row_q;
    assign xlat_col = {tile_idx, 3'b000};

    always_comb begin
        vram_addr = 16'h0000;
        case (state)
            ST_NT:   vram_addr = xlat_nt_ptr;
            ST_AT:   vram_addr = attr_addr;
            ST_PLO:  vram_addr = pat_lo_addr;
            ST_PHI:  vram_addr = pat_lo_addr + PAT_HI_OFFSET;
            default: vram_addr = 16'h0000;
        endcase
    end

    assign vram_req    = (state == ST_NT) || (state == ST_AT) ||
                         (state == ST_PLO) || (state == ST_PHI);
    assign tile_valid  = (state == ST_OUT);
    assign line_done   = (state == ST_DONE);
    assign busy        = (state != ST_IDLE);
    assign tile_pat_lo = lo_q;
    assign tile_pat_hi = hi_q;
    assign tile_pal    = pal_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            row_q      <= 9'd0;
            tile_idx   <= 6'd0;
            nt_ptr_q   <= 16'h0000;
            fine_q     <= 3'd0;
            tile_num_q <= 8'h00;
            lo_q       <= 8'h00;
            hi_q       <= 8'h00;
            pal_q      <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (line_start) begin
                        row_q    <= line_row;
                        tile_idx <= 6'd0;
                        state    <= ST_NT;
                    end
                end
                ST_NT: begin
                    // Translator inputs are constant throughout NT, so the copy taken
                    // at the ack edge is the one the rest of the tile uses.
                    nt_ptr_q <= xlat_nt_ptr;
                    fine_q   <= xlat_fine_row;
                    if (vram_ack) begin
                        tile_num_q <= vram_rdata;
                        state      <= ST_AT;
                    end
                end
                ST_AT: begin
                    if (vram_ack) begin
                        pal_q <= 2'(vram_rdata >> attr_shift);
                        state <= ST_PLO;
                    end
                end
                ST_PLO: begin
                    if (vram_ack) begin
                        lo_q  <= vram_rdata;
                        state <= ST_PHI;
                    end
                end
                ST_PHI: begin
                    if (vram_ack) begin
                        hi_q  <= vram_rdata;
                        state <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (tile_ready) begin
                        if (tile_idx == LAST_TILE) begin
                            state <= ST_DONE;
                        end else begin
                            tile_idx <= tile_idx + 6'd1;
                            state    <= ST_NT;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bg_tile_fetch_seq.sv
// Directed bench for bg_tile_fetch_seq with a behavioural translator and VRAM responder.
module tb_bg_tile_fetch_seq;

    localparam int TPL = 33;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        line_start;
    logic [8:0]  line_row;
    logic [7:0]  ppu_ctrl1;
    logic [8:0]  xlat_row;
    logic [8:0]  xlat_col;
    logic [15:0] xlat_nt_ptr;
    logic [2:0]  xlat_fine_row;
    logic        vram_req;
    logic [15:0] vram_addr;
    logic        vram_ack;
    logic [7:0]  vram_rdata;
    logic        tile_valid;
    logic        tile_ready;
    logic [7:0]  tile_pat_lo;
    logic [7:0]  tile_pat_hi;
    logic [1:0]  tile_pal;
    logic        line_done;
    logic        busy;

    always #5 clk = ~clk;

    bg_tile_fetch_seq #(.TILES_PER_LINE(TPL)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .line_start    (line_start),
        .line_row      (line_row),
        .ppu_ctrl1     (ppu_ctrl1),
        .xlat_row      (xlat_row),
        .xlat_col      (xlat_col),
        .xlat_nt_ptr   (xlat_nt_ptr),
        .xlat_fine_row (xlat_fine_row),
        .vram_req      (vram_req),
        .vram_addr     (vram_addr),
        .vram_ack      (vram_ack),
        .vram_rdata    (vram_rdata),
        .tile_valid    (tile_valid),
        .tile_ready    (tile_ready),
        .tile_pat_lo   (tile_pat_lo),
        .tile_pat_hi   (tile_pat_hi),
        .tile_pal      (tile_pal),
        .line_done     (line_done),
        .busy          (busy)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] acc_log[$];
    logic [17:0] tiles[$];

    logic        use_xovr = 1'b0;
    logic [15:0] xovr_ptr = 16'h0000;
    logic [2:0]  xovr_fine = 3'd0;
    logic        use_movr = 1'b0;
    logic [7:0]  movr_nt = 8'h00;
    logic [7:0]  movr_at = 8'h00;
    int          max_delay = 0;
    int          ack_limit = 1 << 30;
    int          wait_cnt = 0;
    logic        prev_pending = 1'b0;
    logic [15:0] prev_addr = 16'h0000;

    logic [15:0] tab_ptr  [3] = '{16'h2C02, 16'h2C42, 16'h2D98};
    logic [15:0] tab_at   [3] = '{16'h2FC0, 16'h2FC0, 16'h2FDE};
    logic [1:0]  tab_pal  [3] = '{2'd1, 2'd3, 2'd0};

    function automatic logic [15:0] xp(input logic [8:0] row, input logic [8:0] col);
        return 16'h2000 | (col[8] ? 16'h0400 : 16'h0000) | {6'd0, row[7:3], col[7:3]};
    endfunction

    assign xlat_nt_ptr   = use_xovr ? xovr_ptr : xp(xlat_row, xlat_col);
    assign xlat_fine_row = use_xovr ? xovr_fine : xlat_row[2:0];

    function automatic logic [7:0] vmem(input logic [15:0] a);
        if (use_movr) begin
            if (a >= 16'h2000 && a[9:6] == 4'hF) return movr_at;
            if (a >= 16'h2000) return movr_nt;
            return a[7:0] ^ 8'h5A;
        end
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    function automatic logic [15:0] exp_access(input logic [8:0] row, input int t,
                                               input int k, input logic c4);
        logic [15:0] ptr;
        logic [2:0]  fine;
        logic [15:0] at;
        logic [15:0] plo;
        ptr  = use_xovr ? xovr_ptr : xp(row, 9'(t * 8));
        fine = use_xovr ? xovr_fine : row[2:0];
        at   = 16'h23C0 | (ptr & 16'h0C00) | ((ptr >> 4) & 16'h0038) | ((ptr >> 2) & 16'h0007);
        plo  = (c4 ? 16'h1000 : 16'h0000) + {4'd0, vmem(ptr), 4'd0} + {13'd0, fine};
        case (k)
            0:       return ptr;
            1:       return at;
            2:       return plo;
            default: return plo + 16'd8;
        endcase
    endfunction

    function automatic logic [17:0] exp_tile(input logic [8:0] row, input int t, input logic c4);
        logic [15:0] ptr;
        logic [7:0]  attr;
        logic [2:0]  sh;
        ptr  = exp_access(row, t, 0, c4);
        attr = vmem(exp_access(row, t, 1, c4));
        sh   = {ptr[6], ptr[1], 1'b0};
        return {vmem(exp_access(row, t, 2, c4)), vmem(exp_access(row, t, 3, c4)), 2'(attr >> sh)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // VRAM responder and bus monitor, working on the falling edge.
    initial begin
        vram_ack   = 1'b0;
        vram_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (prev_pending && vram_req) chk("addr_stable", vram_addr, prev_addr);
            vram_ack = 1'b0;
            if (vram_req && acc_log.size() < ack_limit) begin
                if (wait_cnt == 0) begin
                    vram_ack   = 1'b1;
                    vram_rdata = vmem(vram_addr);
                    acc_log.push_back(vram_addr);
                    wait_cnt   = int'($urandom_range(0, max_delay));
                end else begin
                    wait_cnt--;
                end
            end
            prev_pending = vram_req && !vram_ack;
            prev_addr    = vram_addr;
            if (tile_valid && tile_ready) tiles.push_back({tile_pat_lo, tile_pat_hi, tile_pal});
        end
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic start_line(input logic [8:0] row);
        line_row   = row;
        line_start = 1'b1;
        step();
        line_start = 1'b0;
    endtask

    task automatic wait_valid(input int bound);
        int n = 0;
        while (!tile_valid && n < bound) begin
            step();
            n++;
        end
        chk("wait_tile_valid", tile_valid, 1'b1);
    endtask

    task automatic check_line(input string tag, input logic [8:0] row, input logic c4);
        chk({tag, "_acc_count"}, acc_log.size(), TPL * 4);
        for (int i = 0; i < acc_log.size() && i < TPL * 4; i++)
            chk({tag, "_acc"}, acc_log[i], exp_access(row, i / 4, i % 4, c4));
        chk({tag, "_tile_count"}, tiles.size(), TPL);
        for (int i = 0; i < tiles.size() && i < TPL; i++)
            chk({tag, "_tile"}, tiles[i], exp_tile(row, i, c4));
    endtask

    initial begin
        int          cnt;
        logic [17:0] held;

        rst_n      = 1'b0;
        line_start = 1'b0;
        line_row   = 9'd0;
        ppu_ctrl1  = 8'h00;
        tile_ready = 1'b1;
        step();
        step();

        chk("rst_vram_req", vram_req, 1'b0);
        chk("rst_vram_addr", vram_addr, 16'h0000);
        chk("rst_tile_valid", tile_valid, 1'b0);
        chk("rst_tile_bits", {tile_pat_lo, tile_pat_hi, tile_pal}, 18'd0);
        chk("rst_line_done", line_done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tile_idx", xlat_col, 9'd0);
        rst_n = 1'b1;
        step();
        chk("idle_busy", busy, 1'b0);

        // Full line, zero-wait VRAM, consumer always ready.
        acc_log.delete();
        tiles.delete();
        start_line(9'd0);
        chk("first_req", vram_req, 1'b1);
        chk("first_nt_addr", vram_addr, 16'h2000);
        cnt = 1;
        while (!line_done && cnt < 2000) begin
            step();
            cnt++;
        end
        // Span counted from the line_start cycle through the line_done cycle inclusive.
        chk("line_len", cnt + 1, 1 + 5 * TPL + 1);
        chk("first_at_addr", acc_log[1], 16'h23C0);
        chk("first_plo_addr", acc_log[2], {4'd0, vmem(16'h2000), 4'd0});
        check_line("line0", 9'd0, 1'b0);
        step();
        chk("line_done_pulse", line_done, 1'b0);
        chk("idle_after_line", busy, 1'b0);

        // Attribute address and palette quadrant selection.
        use_xovr = 1'b1;
        use_movr = 1'b1;
        movr_at  = 8'hE4;
        movr_nt  = 8'h10;
        for (int i = 0; i < 3; i++) begin
            xovr_ptr   = tab_ptr[i];
            xovr_fine  = 3'd0;
            tile_ready = 1'b0;
            acc_log.delete();
            tiles.delete();
            start_line(9'd0);
            wait_valid(50);
            chk("at_addr", acc_log[1], tab_at[i]);
            chk("at_pal", tile_pal, tab_pal[i]);
            if (i == 0) begin
                held = {tile_pat_lo, tile_pat_hi, tile_pal};
                line_start = 1'b1;
                step();
                line_start = 1'b0;
                for (int c = 0; c < 10; c++) begin
                    chk("stall_vram_req", vram_req, 1'b0);
                    step();
                end
                chk("stall_valid", tile_valid, 1'b1);
                chk("stall_tile_held", {tile_pat_lo, tile_pat_hi, tile_pal}, held);
                chk("stall_busy", busy, 1'b1);
                chk("stall_ignored_start", xlat_col, 9'd0);
                tile_ready = 1'b1;
                step();
                chk("after_stall_col", xlat_col, 9'd8);
                chk("after_stall_req", vram_req, 1'b1);
                chk("after_stall_tiles", tiles.size(), 1);
            end
            do_reset();
        end

        // Upper pattern table, tile 0xFF, fine row 7.
        ppu_ctrl1  = 8'h10;
        xovr_ptr   = 16'h2000;
        xovr_fine  = 3'd7;
        movr_nt    = 8'hFF;
        tile_ready = 1'b0;
        acc_log.delete();
        start_line(9'd0);
        wait_valid(50);
        chk("plo_addr_hi_table", acc_log[2], 16'h1FF7);
        chk("phi_addr_hi_table", acc_log[3], 16'h1FFF);
        chk("pat_lo_hi_table", tile_pat_lo, vmem(16'h1FF7));
        chk("pat_hi_hi_table", tile_pat_hi, vmem(16'h1FFF));
        do_reset();
        ppu_ctrl1 = 8'h00;
        use_xovr  = 1'b0;
        use_movr  = 1'b0;

        // Random ack latency and random consumer backpressure over a full line.
        max_delay = 5;
        acc_log.delete();
        tiles.delete();
        start_line(9'd163);
        cnt = 0;
        while (!line_done && cnt < 20000) begin
            tile_ready = 1'($urandom_range(0, 1));
            step();
            cnt++;
        end
        chk("rand_line_done", line_done, 1'b1);
        check_line("rand", 9'd163, 1'b0);
        tile_ready = 1'b1;
        max_delay  = 0;
        wait_cnt   = 0;
        step();

        // Reset while a plane-0 read is outstanding.
        ack_limit = 2;
        acc_log.delete();
        tiles.delete();
        start_line(9'd8);
        cnt = 0;
        while (!(vram_req && acc_log.size() == 2) && cnt < 50) begin
            step();
            cnt++;
        end
        chk("plo_pending_addr", vram_addr, exp_access(9'd8, 0, 2, 1'b0));
        rst_n = 1'b0;
        step();
        chk("midrst_vram_req", vram_req, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_valid", tile_valid, 1'b0);
        chk("midrst_tile_idx", xlat_col, 9'd0);
        rst_n     = 1'b1;
        ack_limit = 1 << 30;
        step();
        acc_log.delete();
        tiles.delete();
        start_line(9'd8);
        chk("restart_col", xlat_col, 9'd0);
        wait_valid(50);
        chk("restart_nt_addr", acc_log[0], exp_access(9'd8, 0, 0, 1'b0));
        chk("restart_tile", {tile_pat_lo, tile_pat_hi, tile_pal}, exp_tile(9'd8, 0, 1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
